// File: rtl/bcd_pkg.sv
// Shared BCD definitions for the binary-to-BCD converter and the seven-segment
// cathode decoder, so both agree on digit width, digit ordering and range.
package bcd_pkg;

  localparam int NIBBLE_W   = 4;
  localparam int DEF_BIN_W  = 14;
  localparam int DEF_DIGITS = 4;

  typedef logic [NIBBLE_W-1:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  // Largest value a display of 'digits' BCD digits can show (10^digits - 1).
  function automatic int bcd_max_val(input int digits);
    int v;
    v = 1;
    for (int i = 0; i < digits; i++) begin
      v = v * 10;
    end
    return v - 1;
  endfunction

  localparam int DEF_MAX_VAL = bcd_max_val(DEF_DIGITS);

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 before the
// next left shift, so the shift carries correctly into the next decade.
module bcd_add3
  import bcd_pkg::*;
(
  input  bcd_digit_t i_digit,
  output bcd_digit_t o_digit
);

  always_comb begin
    o_digit = i_digit;
    if (i_digit >= NIBBLE_W'(5)) begin
      o_digit = i_digit + NIBBLE_W'(3);
    end
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: one shift per clock, result and overflow
// flag held stable between conversions for the scanned display.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W   = DEF_BIN_W,
  parameter int DIGITS  = DEF_DIGITS,
  parameter int MAX_VAL = bcd_max_val(DIGITS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [BIN_W-1:0]           bin_in,
  output logic                       busy,
  output logic                       done,
  output logic [NIBBLE_W*DIGITS-1:0] bcd_out,
  output logic                       ovf
);

  localparam int BCD_W = NIBBLE_W * DIGITS;
  localparam int REG_W = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [BIN_W-1:0] MAX_BIN  = BIN_W'(MAX_VAL);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

  state_t             r_state;
  state_t             w_nextState;
  logic [REG_W-1:0]   r_shreg;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ovfNext;
  logic [BCD_W-1:0]   r_bcdOut;
  logic               r_ovf;

  logic [REG_W-1:0]   w_adjusted;
  logic [REG_W-1:0]   w_shifted;
  logic               w_overRange;
  logic [BIN_W-1:0]   w_binSat;
  logic               w_lastShift;

  assign w_overRange = (bin_in > MAX_BIN);
  assign w_binSat    = w_overRange ? MAX_BIN : bin_in;
  assign w_lastShift = (r_cnt == LAST_CNT);

  for (genvar g = 0; g < DIGITS; g++) begin : gen_add3
    bcd_add3 u_add3 (
      .i_digit (r_shreg[BIN_W + g*NIBBLE_W +: NIBBLE_W]),
      .o_digit (w_adjusted[BIN_W + g*NIBBLE_W +: NIBBLE_W])
    );
  end

  assign w_adjusted[BIN_W-1:0] = r_shreg[BIN_W-1:0];
  assign w_shifted             = w_adjusted << 1;

  always_comb begin
    w_nextState = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_nextState = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (w_lastShift) begin
          w_nextState = DONE;
        end
      end
      DONE: begin
        busy        = 1'b1;
        done        = 1'b1;
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // The result registers load on the final shift so they are already valid
  // during the DONE cycle, together with the done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_shreg   <= '0;
      r_cnt     <= '0;
      r_ovfNext <= 1'b0;
      r_bcdOut  <= '0;
      r_ovf     <= 1'b0;
    end else begin
      r_state <= w_nextState;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_shreg   <= {{BCD_W{1'b0}}, w_binSat};
            r_cnt     <= '0;
            r_ovfNext <= w_overRange;
          end
        end
        SHIFT: begin
          r_shreg <= w_shifted;
          r_cnt   <= r_cnt + CNT_W'(1);
          if (w_lastShift) begin
            r_bcdOut <= w_shifted[REG_W-1 -: BCD_W];
            r_ovf    <= r_ovfNext;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bcd_out = r_bcdOut;
  assign ovf     = r_ovf;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq: expectations are queued at each start and
// checked by a monitor when done pulses.
module tb_bin_to_bcd_seq;

  localparam int BIN_W   = 14;
  localparam int MAX_VAL = 9999;
  localparam int BCD_W   = 16;

  typedef struct {
    int              value;
    logic [BCD_W-1:0] bcd;
    logic            ovf;
    int              cycle;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [BIN_W-1:0] bin_in;
  logic             busy;
  logic             done;
  logic [BCD_W-1:0] bcd_out;
  logic             ovf;

  exp_t sb[$];
  int   checks    = 0;
  int   failures  = 0;
  int   cycle     = 0;
  int   doneCount = 0;

  bin_to_bcd_seq dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bin_in  (bin_in),
    .busy    (busy),
    .done    (done),
    .bcd_out (bcd_out),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  function automatic logic [BCD_W-1:0] refBcd(input int v);
    int s;
    s = (v > MAX_VAL) ? MAX_VAL : v;
    return {4'((s / 1000) % 10), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one accepted start and queue the model's answer for the monitor.
  task automatic applyStimulus(input int v);
    exp_t e;
    @(negedge clk);
    start    = 1'b1;
    bin_in   = BIN_W'(v);
    e.value  = v;
    e.bcd    = refBcd(v);
    e.ovf    = (v > MAX_VAL);
    e.cycle  = cycle + 1 + BIN_W;
    sb.push_back(e);
    @(posedge clk);
    #1;
    start  = 1'b0;
    bin_in = BIN_W'($urandom);
  endtask

  task automatic waitDrain();
    for (int k = 0; k < 100 && sb.size() != 0; k++) begin
      @(negedge clk);
      #1;
    end
    checkOutput("drain", sb.size(), 0);
    sb.delete();
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    logic nibOk;
    if (done === 1'b1) begin
      doneCount++;
      if (sb.size() == 0) begin
        checkOutput("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        checkOutput($sformatf("bcd_%0d", e.value), bcd_out, e.bcd);
        checkOutput($sformatf("ovf_%0d", e.value), ovf, e.ovf);
        checkOutput($sformatf("latency_%0d", e.value), cycle, e.cycle);
        nibOk = (bcd_out[3:0] <= 4'd9) && (bcd_out[7:4] <= 4'd9) &&
                (bcd_out[11:8] <= 4'd9) && (bcd_out[15:12] <= 4'd9);
        checkOutput($sformatf("nibble_range_%0d", e.value), nibOk, 1);
      end
    end
  end

  initial begin
    int busyCount;
    bit doneSeen;
    int dc;
    $display("[TB] bin_to_bcd_seq bench starting");
    rst    = 1'b1;
    start  = 1'b0;
    bin_in = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_bcd", bcd_out, 0);
    checkOutput("reset_ovf", ovf, 0);
    rst = 1'b0;

    // Basic conversion with busy-window length.
    applyStimulus(1234);
    busyCount = 0;
    doneSeen  = 1'b0;
    for (int k = 0; k < 40 && !doneSeen; k++) begin
      @(negedge clk);
      if (busy === 1'b1) busyCount++;
      if (done === 1'b1) doneSeen = 1'b1;
    end
    checkOutput("busy_len", busyCount, 15);
    waitDrain();

    // Back-to-back at the first legal start, then saturation.
    applyStimulus(0);
    waitDrain();
    applyStimulus(9999);
    waitDrain();
    applyStimulus(10000);
    waitDrain();
    applyStimulus(16383);
    waitDrain();

    // Start during a conversion is ignored; old result holds meanwhile.
    applyStimulus(4321);
    repeat (4) @(negedge clk);
    start  = 1'b1;
    bin_in = BIN_W'(8765);
    checkOutput("hold_bcd", bcd_out, 16'h9999);
    checkOutput("hold_ovf", ovf, 1);
    @(posedge clk);
    #1;
    start  = 1'b0;
    bin_in = BIN_W'(1111);
    waitDrain();
    dc = doneCount;
    repeat (20) @(negedge clk);
    checkOutput("no_second_done", doneCount, dc);

    // Reset mid-conversion aborts it.
    applyStimulus(5678);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_bcd", bcd_out, 0);
    checkOutput("abort_ovf", ovf, 0);
    dc = doneCount;
    repeat (20) @(negedge clk);
    checkOutput("abort_no_done", doneCount, dc);
    applyStimulus(42);
    waitDrain();

    // Reset wins over a simultaneous start.
    @(negedge clk);
    start  = 1'b1;
    rst    = 1'b1;
    bin_in = BIN_W'(77);
    @(negedge clk);
    start = 1'b0;
    rst   = 1'b0;
    checkOutput("rst_start_busy", busy, 0);
    checkOutput("rst_start_bcd", bcd_out, 0);
    dc = doneCount;
    repeat (20) @(negedge clk);
    checkOutput("rst_start_no_done", doneCount, dc);

    // Strided sweep across the whole input range plus the saturation edge.
    for (int v = 0; v < 16384; v += 7) begin
      applyStimulus(v);
      waitDrain();
    end
    for (int v = 9990; v <= 10010; v++) begin
      applyStimulus(v);
      waitDrain();
    end
    applyStimulus(16383);
    waitDrain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
